// File: rtl/cgra_pkg.sv
// ============================================================================
// cgra_pkg : shared widths and types for the CGRA kernel fetch controller
// Revision : 1.0
// ============================================================================
`default_nettype none

package cgra_pkg;

  localparam int unsigned IMEM_N_LINES_LOG2   = 5;
  localparam int unsigned KER_CONF_N_REG_LOG2 = 4;
  localparam int unsigned KMEM_WIDTH          = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    KCFG  = 3'd1,
    FETCH = 3'd2,
    WAIT  = 3'd3,
    DONE  = 3'd4
  } kfetch_state_e;

  // Kernel-config word layout; rsvd pads the gap between last and valid.
  typedef struct packed {
    logic                                          valid;
    logic [KMEM_WIDTH-2*IMEM_N_LINES_LOG2-2:0]     rsvd;
    logic [IMEM_N_LINES_LOG2-1:0]                  last;
    logic [IMEM_N_LINES_LOG2-1:0]                  first;
  } ker_conf_t;

endpackage

`default_nettype wire

// File: rtl/cgra_kernel_fetch_ctrl.sv
// ============================================================================
// cgra_kernel_fetch_ctrl : walks a kernel's instruction lines out of context
// memory and pulses rc_load_o per returned line. CGRA_KFETCH_PIPE_EN selects
// back-to-back (1 line/cycle) fetch instead of the 2-cycle handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module cgra_kernel_fetch_ctrl #(
  parameter int unsigned IMEM_N_LINES_LOG2   = cgra_pkg::IMEM_N_LINES_LOG2,
  parameter int unsigned KER_CONF_N_REG_LOG2 = cgra_pkg::KER_CONF_N_REG_LOG2,
  parameter int unsigned KMEM_WIDTH          = cgra_pkg::KMEM_WIDTH
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic [KER_CONF_N_REG_LOG2-1:0] ker_id_i,
  input  logic                           abort_i,
  output logic [KER_CONF_N_REG_LOG2-1:0] kmem_radd_o,
  input  logic [KMEM_WIDTH-1:0]          kmem_rdata_i,
  output logic                           conf_req_o,
  output logic [IMEM_N_LINES_LOG2-1:0]   imem_radd_o,
  input  logic                           imem_gnt_i,
  input  logic                           imem_rvalid_i,
  output logic                           rc_load_o,
  output logic [IMEM_N_LINES_LOG2-1:0]   rc_line_o,
  output logic                           busy_o,
  output logic                           done_o,
  output logic                           err_o
);

  import cgra_pkg::*;

  localparam int unsigned LW = IMEM_N_LINES_LOG2;

  kfetch_state_e                  state_q;
  logic [KER_CONF_N_REG_LOG2-1:0] ker_id_q;
  logic [LW-1:0]                  cur_q;
  logic [LW-1:0]                  last_q;
  logic                           conf_req_q;
  logic                           busy_q;
  logic                           done_q;
  logic                           err_q;

  logic                           cfg_valid;
  logic [LW-1:0]                  cfg_first;
  logic [LW-1:0]                  cfg_last;
  logic [LW-1:0]                  cur_next;
  logic                           load_ok;
  logic                           load_fire;

  assign cfg_valid = kmem_rdata_i[KMEM_WIDTH-1];
  assign cfg_first = kmem_rdata_i[LW-1:0];
  assign cfg_last  = kmem_rdata_i[2*LW-1:LW];
  // Natural overflow gives the modulo-2**L wrap of the line counter.
  assign cur_next  = cur_q + {{(LW-1){1'b0}}, 1'b1};

  if (KMEM_WIDTH > 2*LW+1) begin : g_pad
    logic unused_pad;
    assign unused_pad = ^kmem_rdata_i[KMEM_WIDTH-2:2*LW];
  end

`ifdef CGRA_KFETCH_PIPE_EN
  logic [LW-1:0] prev_q;
  logic          inflight_q;
  assign load_ok   = inflight_q;
  assign rc_line_o = prev_q;
`else
  assign load_ok   = (state_q == WAIT);
  assign rc_line_o = cur_q;
`endif

  // Abort drops any returning line, even one already granted.
  assign load_fire = imem_rvalid_i & load_ok & ~abort_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      ker_id_q   <= '0;
      cur_q      <= '0;
      last_q     <= '0;
      conf_req_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
`ifdef CGRA_KFETCH_PIPE_EN
      prev_q     <= '0;
      inflight_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
`ifdef CGRA_KFETCH_PIPE_EN
      inflight_q <= 1'b0;
`endif
      if (abort_i && state_q != IDLE) begin
        state_q    <= IDLE;
        conf_req_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: if (start_i) begin
            ker_id_q <= ker_id_i;
            busy_q   <= 1'b1;
            state_q  <= KCFG;
          end
          KCFG: if (cfg_valid) begin
            cur_q      <= cfg_first;
            last_q     <= cfg_last;
            conf_req_q <= 1'b1;
            state_q    <= FETCH;
          end else begin
            err_q   <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          FETCH: if (imem_gnt_i) begin
`ifdef CGRA_KFETCH_PIPE_EN
            prev_q     <= cur_q;
            inflight_q <= 1'b1;
            if (cur_q == last_q) begin
              conf_req_q <= 1'b0;
              state_q    <= WAIT;
            end else begin
              cur_q <= cur_next;
            end
`else
            conf_req_q <= 1'b0;
            state_q    <= WAIT;
`endif
          end
          WAIT: if (load_fire) begin
`ifdef CGRA_KFETCH_PIPE_EN
            done_q  <= 1'b1;
            state_q <= DONE;
`else
            if (cur_q == last_q) begin
              done_q  <= 1'b1;
              state_q <= DONE;
            end else begin
              cur_q      <= cur_next;
              conf_req_q <= 1'b1;
              state_q    <= FETCH;
            end
`endif
          end
          DONE: begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
          default: begin
            conf_req_q <= 1'b0;
            busy_q     <= 1'b0;
            state_q    <= IDLE;
          end
        endcase
      end
    end
  end

  assign kmem_radd_o = ker_id_q;
  assign conf_req_o  = conf_req_q;
  assign imem_radd_o = cur_q;
  assign rc_load_o   = load_fire;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

endmodule

`default_nettype wire

// File: tb/tb_cgra_kernel_fetch_ctrl.sv
// ============================================================================
// tb_cgra_kernel_fetch_ctrl : table, hand-written and random launches checked
// against a line-list model of the fetch controller.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_cgra_kernel_fetch_ctrl;
  import cgra_pkg::*;

  localparam int NL = 32;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic [3:0]  ker_id_i = '0;
  logic        abort_i = 1'b0;
  logic [3:0]  kmem_radd_o;
  logic [15:0] kmem_rdata_i;
  logic        conf_req_o;
  logic [4:0]  imem_radd_o;
  logic        imem_gnt_i = 1'b0;
  logic        imem_rvalid_i = 1'b0;
  logic        rc_load_o;
  logic [4:0]  rc_line_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;

  logic [15:0] kmem [16];
  assign kmem_rdata_i = kmem[kmem_radd_o];

  cgra_kernel_fetch_ctrl dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .ker_id_i(ker_id_i),
    .abort_i(abort_i), .kmem_radd_o(kmem_radd_o), .kmem_rdata_i(kmem_rdata_i),
    .conf_req_o(conf_req_o), .imem_radd_o(imem_radd_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .rc_load_o(rc_load_o), .rc_line_o(rc_line_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int   ker;
    logic v;
    int   first;
    int   last;
    int   exp_n;
    int   exp_err;
  } vec_t;
  vec_t vecs[7];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gmode = 0;
  int   stall_line = 0;
  int   stall_left = 0;
  int   stalls, n_req, n_done, n_err, done_cyc, err_cyc, run, max_run, busy_at_done;
  logic rv_next = 1'b0;
  int   loads[$], load_cyc[$], acc[$], acc_cyc[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic put_conf(input int ker, input logic v, input int first, input int last);
    ker_conf_t c;
    c       = '0;
    c.valid = v;
    c.first = 5'(first);
    c.last  = 5'(last);
    kmem[ker] = c;
  endtask

  // One clock: drive at negedge, observe 1 ns later; memory answers a
  // granted request with rvalid exactly one cycle later.
  task automatic tick(input logic st, input logic ab);
    @(negedge clk_i);
    start_i       = st;
    abort_i       = ab;
    imem_rvalid_i = rv_next;
    if (gmode == 2 && stall_left > 0 && conf_req_o && int'(imem_radd_o) == stall_line) begin
      imem_gnt_i = 1'b0;
      stall_left--;
    end else if (gmode == 1) imem_gnt_i = ($urandom_range(3, 0) != 0);
    else imem_gnt_i = 1'b1;
    #1;
    cyc++;
    if (rc_load_o) begin
      loads.push_back(int'(rc_line_o));
      load_cyc.push_back(cyc);
    end
    if (conf_req_o) begin
      n_req++;
      run++;
      if (run > max_run) max_run = run;
      if (imem_gnt_i) begin
        acc.push_back(int'(imem_radd_o));
        acc_cyc.push_back(cyc);
      end else stalls++;
    end else run = 0;
    if (done_o) begin n_done++; done_cyc = cyc; busy_at_done = int'(busy_o); end
    if (err_o)  begin n_err++;  err_cyc  = cyc; end
    rv_next = conf_req_o & imem_gnt_i;
  endtask

  task automatic clear_obs();
    loads.delete(); load_cyc.delete(); acc.delete(); acc_cyc.delete();
    stalls = 0; n_req = 0; n_done = 0; n_err = 0; run = 0; max_run = 0;
    done_cyc = 0; err_cyc = 0; busy_at_done = 0;
  endtask

  task automatic launch(input int ker, input int mode, input int exp_n,
                        input int exp_err, input string tag);
    ker_conf_t c;
    int t0, bad, lat, first;
    c     = ker_conf_t'(kmem[ker]);
    first = int'(c.first);
    clear_obs();
    gmode    = mode;
    ker_id_i = 4'(ker);
    tick(1'b1, 1'b0);
    t0 = cyc;
    for (int i = 0; i < 400 && n_done == 0 && n_err == 0; i++) tick(1'b0, 1'b0);
    chk({tag, " finished"}, n_done + n_err, 1);
    repeat (3) tick(1'b0, 1'b0);
    chk({tag, " busy_after"}, int'(busy_o), 0);
    chk({tag, " done_cnt"}, n_done, 1 - exp_err);
    chk({tag, " err_cnt"}, n_err, exp_err);
    chk({tag, " loads"}, loads.size(), exp_n);
    if (exp_err != 0) begin
      chk({tag, " err_lat"}, err_cyc - t0, 2);
      chk({tag, " req_cnt"}, n_req, 0);
    end else begin
`ifdef CGRA_KFETCH_PIPE_EN
      lat = exp_n + stalls + 3;
`else
      lat = 2 * exp_n + stalls + 2;
`endif
      chk({tag, " done_lat"}, done_cyc - t0, lat);
      chk({tag, " busy_at_done"}, busy_at_done, 1);
      chk({tag, " gnt_cnt"}, acc.size(), exp_n);
    end
    bad = 0;
    for (int i = 0; i < exp_n; i++) begin
      if (i >= loads.size() || loads[i] != (first + i) % NL) bad++;
      else if (i >= acc.size() || acc[i] != loads[i]) bad++;
      else if (load_cyc[i] != acc_cyc[i] + 1) bad++;
    end
    chk({tag, " line_seq"}, bad, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int ker, first, last, n;
    logic v;
    for (int i = 0; i < 16; i++) kmem[i] = '0;

    vecs[0] = '{3,  1'b1, 4,  6,  3,  0};
    vecs[1] = '{0,  1'b1, 30, 1,  4,  0};
    vecs[2] = '{2,  1'b0, 0,  0,  0,  1};
    vecs[3] = '{5,  1'b1, 7,  7,  1,  0};
    vecs[4] = '{15, 1'b1, 0,  31, 32, 0};
    vecs[5] = '{9,  1'b1, 31, 30, 32, 0};
    vecs[6] = '{7,  1'b1, 0,  7,  8,  0};
    foreach (vecs[i]) put_conf(vecs[i].ker, vecs[i].v, vecs[i].first, vecs[i].last);

    repeat (3) @(negedge clk_i);
    #1;
    chk("rst busy", int'(busy_o), 0);
    chk("rst done", int'(done_o), 0);
    chk("rst err", int'(err_o), 0);
    chk("rst conf_req", int'(conf_req_o), 0);
    chk("rst rc_load", int'(rc_load_o), 0);
    chk("rst kmem_radd", int'(kmem_radd_o), 0);
    chk("rst imem_radd", int'(imem_radd_o), 0);
    chk("rst rc_line", int'(rc_line_o), 0);
    rst_ni = 1'b1;

    foreach (vecs[i]) launch(vecs[i].ker, 0, vecs[i].exp_n, vecs[i].exp_err, $sformatf("vec%0d", i));
`ifdef CGRA_KFETCH_PIPE_EN
    chk("pipe req_run", max_run, 8);
`else
    chk("hs req_run", max_run, 1);
`endif

    // Grant withheld for five cycles on line 5.
    put_conf(4, 1'b1, 4, 6);
    stall_line = 5;
    stall_left = 5;
    launch(4, 2, 3, 0, "stall");
    chk("stall cycles", stalls, 5);

    // Abort in the cycle line 4 returns.
    clear_obs();
    gmode    = 0;
    ker_id_i = 4'd3;
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b0);
    tick(1'b0, 1'b1);
    chk("abort rvalid_seen", int'(imem_rvalid_i), 1);
    chk("abort rc_load", loads.size(), 0);
    tick(1'b0, 1'b0);
    chk("abort busy_next", int'(busy_o), 0);
    repeat (6) tick(1'b0, 1'b0);
    chk("abort done", n_done, 0);
    chk("abort loads", loads.size(), 0);
    launch(3, 0, 3, 0, "post_abort");

    // Asynchronous reset in the middle of a long launch.
    clear_obs();
    ker_id_i = 4'd15;
    tick(1'b1, 1'b0);
    repeat (6) tick(1'b0, 1'b0);
    #2 rst_ni = 1'b0;
    #1;
    chk("areset busy", int'(busy_o), 0);
    chk("areset conf_req", int'(conf_req_o), 0);
    rv_next = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    clear_obs();
    repeat (8) tick(1'b0, 1'b0);
    chk("areset quiet", n_done + n_err + loads.size() + n_req, 0);

    for (int r = 0; r < 24; r++) begin
      ker   = $urandom_range(15, 0);
      v     = ($urandom_range(7, 0) != 0);
      first = $urandom_range(NL - 1, 0);
      last  = $urandom_range(NL - 1, 0);
      put_conf(ker, v, first, last);
      n = v ? ((last - first + NL) % NL) + 1 : 0;
      launch(ker, 1, n, v ? 0 : 1, $sformatf("rnd%0d", r));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
